fetch_pc_predictor: RTL and testbench
=====================================

# fetch_pc_predictor

Fetch-stage next-PC generator for the branch-prediction datapath. It consumes the branch target buffer's IF-stage lookup (hit, 2-bit predict state, target) and selects the next fetch PC. It also carries each fetch's prediction into ID and compares it against the resolved branch there. When they differ it raises `misprediction`, which feeds back to the branch target buffer's counter update, and it redirects fetch and squashes the wrong-path instruction.

## Interface
Parameters:
- `DATA_WIDTH`, 32, PC / address width
- `RESET_PC`, 0, PC value loaded by reset

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  pipeline advance; low = stall, all state holds
- `btb_hit`  in  1  BTB hit for current `pc`
- `btb_taken`  in  `BTB_PREDICT_SIZE` (2)  predict state of hit line
- `btb_branch_addr`  in  DATA_WIDTH  predicted target from BTB
- `ID_branch`  in  1  instruction in ID is a branch/jump
- `ID_branch_taken`  in  1  resolved outcome in ID
- `ID_branch_addr`  in  DATA_WIDTH  resolved target in ID
- `pc`  out  DATA_WIDTH  current fetch PC (drives BTB `IF_branch_pc`)
- `ID_pc`  out  DATA_WIDTH  PC of instruction now in ID
- `ID_valid`  out  1  ID slot holds a non-squashed instruction
- `misprediction`  out  1  ID prediction wrong, combinational
- `flush`  out  1  squash IF instruction; equals `misprediction`
- `branch_count`  out  32  resolved branches (stats)
- `mispredict_count`  out  32  mispredictions (stats)

## Operation
- Prediction in IF: `pred_taken = btb_hit & btb_taken[1]`. MSB set means STRONGLY/WEAKLY_TAKEN. `pred_addr = pred_taken ? btb_branch_addr : pc + 4`.
- IF→ID record, loaded when `en`: `ID_pc <= pc`, `ID_pred_taken <= pred_taken`, `ID_pred_addr <= pred_addr`, `ID_valid <= ~misprediction`.
- Correct next PC for ID instruction: `actual_addr = (ID_branch & ID_branch_taken) ? ID_branch_addr : ID_pc + 4`.
- `misprediction = ID_valid & (ID_pred_addr != actual_addr)`.
  - Covers wrong direction, wrong target, and a non-branch predicted taken (stale BTB entry).
  - Not-taken predicted correctly as not-taken never flags.
- Next PC, loaded when `en`: `misprediction ? actual_addr : pred_addr`.
- Adders are modulo 2^DATA_WIDTH; `0xFFFFFFFC + 4` wraps to 0.
- Priority: misprediction redirect > BTB prediction > sequential.

## Timing
- Reset (async, immediate):
  - `pc = RESET_PC`, `ID_pc = 0`, `ID_valid = 0`.
  - ID_pred_taken/ID_pred_addr = 0; counters = 0.
  - `misprediction = flush = 0`.
- Reset mid-operation discards the in-flight ID record. The first edge after release fetches from RESET_PC.
- Taken-predicted correct branch: zero bubbles; the target is fetched in the cycle after the branch's fetch.
- Misprediction penalty is exactly one cycle:
  - `misprediction` is high during the ID cycle.
  - On the next enabled edge, `pc <= actual_addr` and `ID_valid <= 0`.
  - The next cycle therefore never flags.
- `en` low: all registers hold. `misprediction` may remain high combinationally and takes effect on the first enabled edge.
- Simultaneous BTB hit-taken in IF and misprediction in ID: the redirect wins and the IF prediction is discarded.

## Configuration
- `PRED_STATS_EN` defined:
  - `branch_count` increments on each enabled edge with `ID_valid & ID_branch`.
  - `mispredict_count` increments on each enabled edge with `misprediction`.
  - Both wrap at 2^32 and clear on reset.
- `PRED_STATS_EN` undefined: no counter registers; both outputs tied to 0.

## Test plan
- Reset with RESET_PC=0x100, no BTB hits, no branches → `pc` = 0x100, 0x104, 0x108…; `ID_valid` high from the second cycle; `misprediction` never asserts.
- At pc=0x10: `btb_hit=1`, `btb_taken=2'b11`, addr=0x40; next cycle ID resolves taken to 0x40 → `pc` goes 0x10→0x40 with no bubble; `misprediction=0`.
- At pc=0x20: BTB miss; ID resolves taken to 0x80 → `misprediction=1` for one cycle; `pc` becomes 0x80; following `ID_valid=0`; `mispredict_count=1` with PRED_STATS_EN.
- At pc=0x30: `btb_taken=2'b10` to 0x60; ID sees a non-branch → `misprediction=1`; `pc` redirects to 0x34.
- Misprediction pending with `en=0` for 3 cycles → `pc` and `ID_pc` hold, `misprediction` stays high; the redirect occurs on the first edge with `en=1`.
- Assert `rst` asynchronously mid-redirect → `pc=RESET_PC` and `misprediction=0` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_predictor.sv
// Fetch-stage next-PC generator: BTB-driven prediction in IF, resolution check in ID.
// Optional statistics counters enabled by defining PRED_STATS_EN.
module fetch_pc_predictor #(
  parameter int unsigned           DATA_WIDTH       = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC         = '0,
  parameter int unsigned           BTB_PREDICT_SIZE = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        btb_hit,
  input  logic [BTB_PREDICT_SIZE-1:0] btb_taken,
  input  logic [DATA_WIDTH-1:0]       btb_branch_addr,
  input  logic                        ID_branch,
  input  logic                        ID_branch_taken,
  input  logic [DATA_WIDTH-1:0]       ID_branch_addr,
  output logic [DATA_WIDTH-1:0]       pc,
  output logic [DATA_WIDTH-1:0]       ID_pc,
  output logic                        ID_valid,
  output logic                        misprediction,
  output logic                        flush,
  output logic [31:0]                 branch_count,
  output logic [31:0]                 mispredict_count
);

  logic                  pred_taken;
  logic [DATA_WIDTH-1:0] pred_addr;
  logic [DATA_WIDTH-1:0] actual_addr;
  logic [DATA_WIDTH-1:0] next_pc;
  logic [DATA_WIDTH-1:0] id_pred_addr;

  // Only the MSB of the predict state selects direction; lower bits are hysteresis.
  logic unused_predict_bits;
  assign unused_predict_bits = ^btb_taken[BTB_PREDICT_SIZE-2:0];

  always_comb begin
    pred_taken    = btb_hit & btb_taken[BTB_PREDICT_SIZE-1];
    pred_addr     = pred_taken ? btb_branch_addr : pc + DATA_WIDTH'(4);
    actual_addr   = (ID_branch & ID_branch_taken) ? ID_branch_addr : ID_pc + DATA_WIDTH'(4);
    misprediction = ID_valid & (id_pred_addr != actual_addr);
    next_pc       = misprediction ? actual_addr : pred_addr;
  end

  assign flush = misprediction;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      ID_pc        <= '0;
      ID_valid     <= 1'b0;
      id_pred_addr <= '0;
    end else if (en) begin
      pc           <= next_pc;
      ID_pc        <= pc;
      ID_valid     <= ~misprediction;
      id_pred_addr <= pred_addr;
    end
  end

`ifdef PRED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (en) begin
      if (ID_valid & ID_branch) branch_count <= branch_count + 32'd1;
      if (misprediction)        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed-vector bench for fetch_pc_predictor; driver queues expected per-cycle
// state and a negedge monitor pops and compares.
module tb_fetch_pc_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        btb_hit = 1'b0;
  logic [1:0]  btb_taken = '0;
  logic [31:0] btb_branch_addr = '0;
  logic        ID_branch = 1'b0;
  logic        ID_branch_taken = 1'b0;
  logic [31:0] ID_branch_addr = '0;
  logic [31:0] pc, ID_pc, branch_count, mispredict_count;
  logic        ID_valid, misprediction, flush;

  fetch_pc_predictor #(
    .DATA_WIDTH(32),
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .btb_hit(btb_hit), .btb_taken(btb_taken), .btb_branch_addr(btb_branch_addr),
    .ID_branch(ID_branch), .ID_branch_taken(ID_branch_taken), .ID_branch_addr(ID_branch_addr),
    .pc(pc), .ID_pc(ID_pc), .ID_valid(ID_valid), .misprediction(misprediction), .flush(flush),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

`ifdef PRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int          idx;
    logic [31:0] pc, id_pc;
    logic        id_valid, mis;
    logic [31:0] bc, mc;
  } exp_t;

  typedef struct {
    logic        rst, en, hit;
    logic [1:0]  taken;
    logic [31:0] baddr;
    logic        idb, idt;
    logic [31:0] idaddr;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t expq[$];
  int   compared = 0;
  int   mismatched = 0;

  task automatic add(input logic r, input logic e_n, input logic h, input logic [1:0] tk,
                     input logic [31:0] ba, input logic ib, input logic it, input logic [31:0] ia,
                     input logic [31:0] xpc, input logic [31:0] xidpc, input logic xv,
                     input logic xmis, input logic [31:0] xbc, input logic [31:0] xmc);
    vec_t v;
    v.rst = r; v.en = e_n; v.hit = h; v.taken = tk; v.baddr = ba;
    v.idb = ib; v.idt = it; v.idaddr = ia;
    v.e.idx = vecs.size();
    v.e.pc = xpc; v.e.id_pc = xidpc; v.e.id_valid = xv; v.e.mis = xmis;
    v.e.bc = STATS ? xbc : 32'd0;
    v.e.mc = STATS ? xmc : 32'd0;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("pc",            e.idx, pc, e.pc);
      chk("ID_pc",         e.idx, ID_pc, e.id_pc);
      chk("ID_valid",      e.idx, 32'(ID_valid), 32'(e.id_valid));
      chk("misprediction", e.idx, 32'(misprediction), 32'(e.mis));
      chk("flush",         e.idx, 32'(flush), 32'(e.mis));
      chk("branch_count",  e.idx, branch_count, e.bc);
      chk("mispred_count", e.idx, mispredict_count, e.mc);
    end
  end

  initial begin
    //   rst en hit tk baddr          idb idt idaddr        | pc           ID_pc        v mis bc mc
    add(1, 0, 0, 2'd0, 32'h0,          0, 0, 32'h0,          32'h100,      32'h0,       0, 0, 0, 0);
    add(0, 1, 0, 2'd0, 32'h0,          0, 0, 32'h0,          32'h100,      32'h0,       0, 0, 0, 0);
    add(0, 1, 0, 2'd0, 32'h0,          0, 0, 32'h0,          32'h104,      32'h100,     1, 0, 0, 0);
    add(0, 1, 0, 2'd0, 32'h0,          0, 0, 32'h0,          32'h108,      32'h104,     1, 0, 0, 0);
    add(0, 1, 0, 2'd0, 32'h0,          1, 1, 32'h10,         32'h10C,      32'h108,     1, 1, 0, 0);
    add(0, 1, 1, 2'd3, 32'h40,         0, 0, 32'h0,          32'h10,       32'h10C,     0, 0, 1, 1);
    add(0, 1, 0, 2'd0, 32'h0,          1, 1, 32'h40,         32'h40,       32'h10,      1, 0, 1, 1);
    add(0, 1, 1, 2'd3, 32'h20,         0, 0, 32'h0,          32'h44,       32'h40,      1, 0, 2, 1);
    add(0, 1, 0, 2'd0, 32'h0,          1, 1, 32'h20,         32'h20,       32'h44,      1, 0, 2, 1);
    // BTB hit-taken in IF while ID mispredicts: redirect to 0x80 must win
    add(0, 1, 1, 2'd3, 32'h200,        1, 1, 32'h80,         32'h24,       32'h20,      1, 1, 3, 1);
    add(0, 1, 0, 2'd0, 32'h0,          1, 1, 32'h300,        32'h80,       32'h24,      0, 0, 4, 2);
    add(0, 1, 1, 2'd3, 32'h30,         0, 0, 32'h0,          32'h84,       32'h80,      1, 0, 4, 2);
    add(0, 1, 1, 2'd2, 32'h60,         1, 1, 32'h30,         32'h30,       32'h84,      1, 0, 4, 2);
    add(0, 0, 0, 2'd0, 32'h0,          0, 0, 32'h0,          32'h60,       32'h30,      1, 1, 5, 2);
    add(0, 0, 0, 2'd0, 32'h0,          0, 0, 32'h0,          32'h60,       32'h30,      1, 1, 5, 2);
    add(0, 0, 0, 2'd0, 32'h0,          0, 0, 32'h0,          32'h60,       32'h30,      1, 1, 5, 2);
    add(0, 1, 0, 2'd0, 32'h0,          0, 0, 32'h0,          32'h60,       32'h30,      1, 1, 5, 2);
    add(0, 1, 1, 2'd1, 32'h500,        0, 0, 32'h0,          32'h34,       32'h60,      0, 0, 5, 3);
    add(0, 1, 0, 2'd0, 32'h0,          1, 0, 32'h999,        32'h38,       32'h34,      1, 0, 5, 3);
    add(0, 1, 1, 2'd3, 32'hFFFF_FFFC,  0, 0, 32'h0,          32'h3C,       32'h38,      1, 0, 6, 3);
    add(0, 1, 0, 2'd0, 32'h0,          1, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h3C,     1, 0, 6, 3);
    add(0, 1, 0, 2'd0, 32'h0,          0, 0, 32'h0,          32'h0,        32'hFFFF_FFFC, 1, 0, 7, 3);
    add(0, 0, 0, 2'd0, 32'h0,          1, 1, 32'h700,        32'h4,        32'h0,       1, 1, 7, 3);
    // Reset asserted with a redirect pending and no clock edge before sampling
    add(1, 1, 0, 2'd0, 32'h0,          1, 1, 32'h700,        32'h100,      32'h0,       0, 0, 0, 0);
    add(0, 1, 0, 2'd0, 32'h0,          0, 0, 32'h0,          32'h100,      32'h0,       0, 0, 0, 0);
    add(0, 1, 0, 2'd0, 32'h0,          0, 0, 32'h0,          32'h104,      32'h100,     1, 0, 0, 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst             = vecs[i].rst;
      en              = vecs[i].en;
      btb_hit         = vecs[i].hit;
      btb_taken       = vecs[i].taken;
      btb_branch_addr = vecs[i].baddr;
      ID_branch       = vecs[i].idb;
      ID_branch_taken = vecs[i].idt;
      ID_branch_addr  = vecs[i].idaddr;
      expq.push_back(vecs[i].e);
    end

    for (int k = 0; k < 4 && expq.size() != 0; k++) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
